logic_reduce_unit: RTL and testbench

- Parametrised successor to the team's 2-input 1-bit gate primitives: reduces NUM_IN operands of WIDTH bits each with a run-time selected bitwise function (AND/OR/XOR/NAND/NOR/XNOR).
- Registered output with valid/ready handshake, plus an accumulate mode that folds successive input beats into a running result.
- Used as the generic logic/reduction stage in datapaths that previously instantiated fixed gates.

---
 rtl/logic_reduce_unit_pkg.sv | 43 ++++
 rtl/logic_reduce_unit_if.sv | 32 +++
 rtl/logic_reduce_tree.sv | 28 ++
 rtl/logic_reduce_unit.sv | 98 +++++++++
 tb/tb_logic_reduce_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/logic_reduce_unit_pkg.sv
// Shared definitions for the logic reduction unit: op encoding and the
// decode of an op into a base function plus output inversion.
package logic_reduce_unit_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_OR     = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_NAND   = 3'd3;
    localparam logic [2:0] OP_NOR    = 3'd4;
    localparam logic [2:0] OP_XNOR   = 3'd5;
    localparam logic [2:0] OP_RSV_LO = 3'd6;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_e;

    typedef struct packed {
        base_e base;
        logic  inv;
        logic  rsv;
    } op_dec_t;

    // Reserved ops fall back to a plain OR so the datapath always does something defined.
    function automatic op_dec_t decode_op(input logic [2:0] op);
        op_dec_t d;
        d.base = BASE_OR;
        d.inv  = 1'b0;
        d.rsv  = (op >= OP_RSV_LO);
        case (op)
            OP_AND:  begin d.base = BASE_AND; d.inv = 1'b0; end
            OP_OR:   begin d.base = BASE_OR;  d.inv = 1'b0; end
            OP_XOR:  begin d.base = BASE_XOR; d.inv = 1'b0; end
            OP_NAND: begin d.base = BASE_AND; d.inv = 1'b1; end
            OP_NOR:  begin d.base = BASE_OR;  d.inv = 1'b1; end
            OP_XNOR: begin d.base = BASE_XOR; d.inv = 1'b1; end
            default: begin d.base = BASE_OR;  d.inv = 1'b0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/logic_reduce_unit_if.sv
// Bus bundle of the logic reduction unit: input beat, output result and status.
interface logic_reduce_unit_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 8
);
    // Both sides use valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both high; valid (and its data) must hold until then.
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic [2:0]                op;
    logic                      acc_en;
    logic                      acc_clr;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_any;
    logic                      op_err;
    logic [CNT_W-1:0]          beat_cnt;

    modport master (
        output in_valid, in_data, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, out_any, op_err, beat_cnt
    );

    modport slave (
        input  in_valid, in_data, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, out_data, out_any, op_err, beat_cnt
    );

endinterface

// File: rtl/logic_reduce_tree.sv
// Combinational bitwise reduction of NUM_IN operands with a selectable base function.
module logic_reduce_tree
    import logic_reduce_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  base_e                   i_base,
    output logic [WIDTH-1:0]        o_red
);

    logic [WIDTH-1:0] w_red;

    always_comb begin
        w_red = i_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            case (i_base)
                BASE_AND: w_red = w_red & i_data[k*WIDTH +: WIDTH];
                BASE_OR:  w_red = w_red | i_data[k*WIDTH +: WIDTH];
                default:  w_red = w_red ^ i_data[k*WIDTH +: WIDTH];
            endcase
        end
    end

    assign o_red = w_red;

endmodule

// File: rtl/logic_reduce_unit.sv
// Registered NUM_IN-way bitwise reduction with run-time op, accumulate mode,
// saturating beat counter and sticky reserved-op flag.
module logic_reduce_unit
    import logic_reduce_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_reduce_unit_if.slave   bus
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_any;
    logic             r_op_err;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [WIDTH-1:0] r_acc;
    logic             r_acc_first;

    op_dec_t          w_dec;
    logic             w_accept;
    logic             w_consume;
    logic [WIDTH-1:0] w_red;
    logic [WIDTH-1:0] w_fold;
    logic             w_first;
    logic [WIDTH-1:0] w_new_acc;
    logic [WIDTH-1:0] w_pre;
    logic [WIDTH-1:0] w_res;
    logic [CNT_W-1:0] w_cnt_base;

    assign w_dec     = decode_op(bus.op);
    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_consume = r_out_valid && bus.out_ready;

    logic_reduce_tree #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_tree (
        .i_data (bus.in_data),
        .i_base (w_dec.base),
        .o_red  (w_red)
    );

    // Second, two-input tree folds the new reduction into the running accumulator.
    logic_reduce_tree #(.WIDTH(WIDTH), .NUM_IN(2)) u_fold (
        .i_data ({w_red, r_acc}),
        .i_base (w_dec.base),
        .o_red  (w_fold)
    );

    // A same-edge clear makes this beat the first one of a fresh accumulation.
    assign w_first    = bus.acc_clr || r_acc_first;
    assign w_new_acc  = w_first ? w_red : w_fold;
    assign w_pre      = bus.acc_en ? w_new_acc : w_red;
    assign w_res      = w_dec.inv ? ~w_pre : w_pre;
    assign w_cnt_base = bus.acc_clr ? '0 : r_beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_any   <= 1'b0;
            r_op_err    <= 1'b0;
            r_beat_cnt  <= '0;
            r_acc       <= '0;
            r_acc_first <= 1'b1;
        end else begin
            if (bus.acc_clr) begin
                r_acc       <= '0;
                r_acc_first <= 1'b1;
                r_beat_cnt  <= '0;
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_any   <= |w_res;
                if (w_dec.rsv) begin
                    r_op_err <= 1'b1;
                end
                if (bus.acc_en) begin
                    r_acc       <= w_new_acc;
                    r_acc_first <= 1'b0;
                    r_beat_cnt  <= (&w_cnt_base) ? w_cnt_base : w_cnt_base + 1'b1;
                end
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_any   = r_out_any;
    assign bus.op_err    = r_op_err;
    assign bus.beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed bench for logic_reduce_unit at WIDTH=4, NUM_IN=2, CNT_W=3.
module tb_logic_reduce_unit;

    localparam int WIDTH  = 4;
    localparam int NUM_IN = 2;
    localparam int CNT_W  = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic_reduce_unit_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) bus ();

    logic_reduce_unit #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a beat (operand 0 = a, operand 1 = b) with in_valid high.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o,
                         input logic ae, input logic clr);
        bus.in_data  = {b, a};
        bus.op       = o;
        bus.acc_en   = ae;
        bus.acc_clr  = clr;
        bus.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 4'h0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        n_cmp++; if (bus.out_any !== 1'b0) begin n_err++; $display("FAIL reset_out_any: got %b expected 0", bus.out_any); end
        n_cmp++; if (bus.op_err !== 1'b0) begin n_err++; $display("FAIL reset_op_err: got %b expected 0", bus.op_err); end
        n_cmp++; if (bus.beat_cnt !== 3'd0) begin n_err++; $display("FAIL reset_beat_cnt: got %0d expected 0", bus.beat_cnt); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_op_sweep();
        logic [3:0] exp_tab [6];
        exp_tab = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001};
        for (int o = 0; o < 6; o++) begin
            drive(4'b1100, 4'b1010, o[2:0], 1'b0, 1'b0);
            step();
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL sweep_valid op=%0d: got %b expected 1", o, bus.out_valid); end
            n_cmp++; if (bus.out_data !== exp_tab[o]) begin n_err++; $display("FAIL sweep_data op=%0d: got %b expected %b", o, bus.out_data, exp_tab[o]); end
        end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sweep_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        drive(4'b1100, 4'b1010, 3'd0, 1'b0, 1'b0);
        step();
        n_cmp++; if (bus.out_data !== 4'b1000) begin n_err++; $display("FAIL bp_first: got %b expected 1000", bus.out_data); end
        bus.out_ready = 1'b0;
        drive(4'b1100, 4'b1010, 3'd1, 1'b0, 1'b0);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_drop: got %b expected 0", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid %0d: got %b expected 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_data !== 4'b1000) begin n_err++; $display("FAIL bp_hold_data %0d: got %b expected 1000", i, bus.out_data); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready %0d: got %b expected 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid: got %b expected 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 4'b1110) begin n_err++; $display("FAIL bp_next_data: got %b expected 1110", bus.out_data); end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_consume: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_accumulate();
        logic [3:0] beat_tab [3];
        logic [3:0] exp_tab  [3];
        beat_tab = '{4'b0001, 4'b0010, 4'b1000};
        exp_tab  = '{4'b0001, 4'b0011, 4'b1011};
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b1;
        step();
        bus.acc_clr = 1'b0;
        n_cmp++; if (bus.beat_cnt !== 3'd0) begin n_err++; $display("FAIL acc_clr_cnt: got %0d expected 0", bus.beat_cnt); end
        for (int i = 0; i < 3; i++) begin
            drive(beat_tab[i], 4'b0000, 3'd1, 1'b1, 1'b0);
            step();
            n_cmp++; if (bus.out_data !== exp_tab[i]) begin n_err++; $display("FAIL acc_or_data %0d: got %b expected %b", i, bus.out_data, exp_tab[i]); end
            n_cmp++; if (bus.beat_cnt !== 3'(i + 1)) begin n_err++; $display("FAIL acc_or_cnt %0d: got %0d expected %0d", i, bus.beat_cnt, i + 1); end
        end
        drive(4'b0000, 4'b0000, 3'd4, 1'b1, 1'b0);
        step();
        n_cmp++; if (bus.out_data !== 4'b0100) begin n_err++; $display("FAIL acc_nor_data: got %b expected 0100", bus.out_data); end
        n_cmp++; if (bus.beat_cnt !== 3'd4) begin n_err++; $display("FAIL acc_nor_cnt: got %0d expected 4", bus.beat_cnt); end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_clear_collision();
        drive(4'b0110, 4'b0110, 3'd2, 1'b1, 1'b1);
        step();
        n_cmp++; if (bus.out_data !== 4'b0000) begin n_err++; $display("FAIL clr_col_data: got %b expected 0000", bus.out_data); end
        n_cmp++; if (bus.out_any !== 1'b0) begin n_err++; $display("FAIL clr_col_any: got %b expected 0", bus.out_any); end
        n_cmp++; if (bus.beat_cnt !== 3'd1) begin n_err++; $display("FAIL clr_col_cnt: got %0d expected 1", bus.beat_cnt); end
        drive(4'b0001, 4'b0000, 3'd2, 1'b1, 1'b0);
        step();
        n_cmp++; if (bus.out_data !== 4'b0001) begin n_err++; $display("FAIL clr_next_data: got %b expected 0001", bus.out_data); end
        n_cmp++; if (bus.out_any !== 1'b1) begin n_err++; $display("FAIL clr_next_any: got %b expected 1", bus.out_any); end
        n_cmp++; if (bus.beat_cnt !== 3'd2) begin n_err++; $display("FAIL clr_next_cnt: got %0d expected 2", bus.beat_cnt); end
        for (int n = 3; n <= 9; n++) begin
            drive(4'b0000, 4'b0000, 3'd1, 1'b1, 1'b0);
            step();
            n_cmp++;
            if (bus.beat_cnt !== 3'((n > 7) ? 7 : n)) begin
                n_err++; $display("FAIL sat_cnt beat %0d: got %0d expected %0d", n, bus.beat_cnt, (n > 7) ? 7 : n);
            end
        end
        bus.in_valid = 1'b0;
        step();
    endtask

    task automatic test_reserved();
        n_cmp++; if (bus.op_err !== 1'b0) begin n_err++; $display("FAIL rsv_before: got %b expected 0", bus.op_err); end
        drive(4'b0101, 4'b0010, 3'd7, 1'b0, 1'b0);
        step();
        n_cmp++; if (bus.out_data !== 4'b0111) begin n_err++; $display("FAIL rsv_data: got %b expected 0111", bus.out_data); end
        n_cmp++; if (bus.op_err !== 1'b1) begin n_err++; $display("FAIL rsv_err_set: got %b expected 1", bus.op_err); end
        drive(4'b1111, 4'b1111, 3'd0, 1'b0, 1'b0);
        step();
        n_cmp++; if (bus.out_data !== 4'b1111) begin n_err++; $display("FAIL rsv_after_data: got %b expected 1111", bus.out_data); end
        n_cmp++; if (bus.op_err !== 1'b1) begin n_err++; $display("FAIL rsv_err_sticky: got %b expected 1", bus.op_err); end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.op_err !== 1'b1) begin n_err++; $display("FAIL rsv_err_idle: got %b expected 1", bus.op_err); end
    endtask

    task automatic test_async_reset();
        drive(4'b1100, 4'b1010, 3'd1, 1'b0, 1'b0);
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre_valid: got %b expected 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ar_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 4'h0) begin n_err++; $display("FAIL ar_out_data: got %h expected 0", bus.out_data); end
        n_cmp++; if (bus.out_any !== 1'b0) begin n_err++; $display("FAIL ar_out_any: got %b expected 0", bus.out_any); end
        n_cmp++; if (bus.op_err !== 1'b0) begin n_err++; $display("FAIL ar_op_err: got %b expected 0", bus.op_err); end
        n_cmp++; if (bus.beat_cnt !== 3'd0) begin n_err++; $display("FAIL ar_beat_cnt: got %0d expected 0", bus.beat_cnt); end
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        drive(4'b0001, 4'b0000, 3'd1, 1'b1, 1'b0);
        step();
        n_cmp++; if (bus.out_data !== 4'b0001) begin n_err++; $display("FAIL ar_acc_first_data: got %b expected 0001", bus.out_data); end
        n_cmp++; if (bus.beat_cnt !== 3'd1) begin n_err++; $display("FAIL ar_acc_first_cnt: got %0d expected 1", bus.beat_cnt); end
        bus.in_valid = 1'b0;
        step();
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.op        = 3'd0;
        bus.acc_en    = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_op_sweep();
        test_backpressure();
        test_accumulate();
        test_clear_collision();
        test_reserved();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
